// File: rtl/codec_pkg.sv
// codec_pkg: shared state encoding and framing modes for the codec serial port
package codec_pkg;
  typedef enum logic [2:0] {IDLE, SYNC, WARM, RUN, HOLD} codec_state_t;
  localparam int MODE_LJ = 0;
  localparam int MODE_I2S = 1;
endpackage

// File: rtl/codec_clkgen.sv
// codec_clkgen: frame counter producing MCLK/SCLK/LRCLK and one-clk-early edge strobes
module codec_clkgen #(
  parameter int SCLK_DIV_LOG2 = 4,
  parameter int SLOT_LOG2 = 4,
  parameter int MCLK_BIT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic MCLK,
  output logic SCLK,
  output logic LRCLK,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic lr_rise,
  output logic lr_fall
);
  localparam int CNT_W = SCLK_DIV_LOG2 + SLOT_LOG2 + 2;
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= {1'b1, {(CNT_W-1){1'b0}}};
    else if (run) cnt <= cnt + CNT_W'(1);
  assign MCLK = cnt[MCLK_BIT];
  assign SCLK = cnt[SCLK_DIV_LOG2];
  assign LRCLK = cnt[CNT_W-1];
  // strobes mark the clk before the edge so registered logic updates on the edge itself
  assign sclk_rise = cnt[SCLK_DIV_LOG2:0] == {1'b0, {SCLK_DIV_LOG2{1'b1}}};
  assign sclk_fall = &cnt[SCLK_DIV_LOG2:0];
  assign lr_rise = cnt == {1'b0, {(CNT_W-1){1'b1}}};
  assign lr_fall = &cnt;
endmodule

// File: rtl/codec_serial_port.sv
// codec_serial_port: parametrised stereo codec serial interface with warm-up and frame-aligned enable
module codec_serial_port import codec_pkg::*; #(
  parameter int DATA_W = 16,
  parameter int SCLK_DIV_LOG2 = 4,
  parameter int SLOT_LOG2 = 4,
  parameter int MCLK_BIT = 1,
  parameter int MODE = MODE_LJ,
  parameter int WARMUP_FRAMES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [DATA_W-1:0] lft_out,
  input  logic [DATA_W-1:0] rht_out,
  input  logic              SDout,
  output logic [DATA_W-1:0] lft_in,
  output logic [DATA_W-1:0] rht_in,
  output logic              valid,
  output logic              LRCLK,
  output logic              SCLK,
  output logic              MCLK,
  output logic              RSTn,
  output logic              SDin
);
  localparam int SR_W = DATA_W + MODE;
  localparam int BC_W = SLOT_LOG2 + 1;
  codec_state_t state, state_nx;
  logic sclk_rise, sclk_fall, lr_rise, lr_fall, keep;
  logic [7:0] frames;
  logic [DATA_W-1:0] lbuf, rbuf, rx_sr, lhold;
  logic [SR_W-1:0] tx_sr;
  logic [BC_W-1:0] bit_cnt;

  codec_clkgen #(
    .SCLK_DIV_LOG2(SCLK_DIV_LOG2),
    .SLOT_LOG2(SLOT_LOG2),
    .MCLK_BIT(MCLK_BIT)
  ) u_clkgen (
    .clk(clk),
    .rst(rst),
    .run(state != IDLE),
    .MCLK(MCLK),
    .SCLK(SCLK),
    .LRCLK(LRCLK),
    .sclk_rise(sclk_rise),
    .sclk_fall(sclk_fall),
    .lr_rise(lr_rise),
    .lr_fall(lr_fall)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = SYNC;
      SYNC: state_nx = LRCLK ? SYNC : WARM;
      WARM: state_nx = (lr_rise && frames == 8'(WARMUP_FRAMES - 1)) ? RUN : WARM;
      RUN:  state_nx = (lr_rise && !enable) ? HOLD : RUN;
      HOLD: state_nx = (lr_rise && enable) ? RUN : HOLD;
      default: state_nx = IDLE;
    endcase
  end

  // I2S drops the first bit period of each slot on receive
  assign keep = bit_cnt != '0 || MODE == MODE_LJ;
  assign SDin = state == RUN && tx_sr[SR_W-1];

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      frames <= '0;
      RSTn <= 1'b0;
      valid <= 1'b0;
      lbuf <= '0;
      rbuf <= '0;
      tx_sr <= '0;
      rx_sr <= '0;
      lhold <= '0;
      bit_cnt <= '0;
      lft_in <= '0;
      rht_in <= '0;
    end else begin
      state <= state_nx;
      frames <= (state == WARM) ? frames + 8'(lr_rise) : '0;
      RSTn <= RSTn | (state == SYNC && !LRCLK);
      valid <= lr_rise && state == RUN;
      if (valid) begin
        lbuf <= lft_out;
        rbuf <= rht_out;
      end
      // the extra top bit in I2S mode is a zero that delays the MSB by one SCLK
      if (lr_rise) tx_sr <= SR_W'(lbuf);
      else if (lr_fall) tx_sr <= SR_W'(rbuf);
      else if (sclk_fall) tx_sr <= tx_sr << 1;
      if (lr_rise || lr_fall) bit_cnt <= '0;
      else if (sclk_rise && bit_cnt != BC_W'(SR_W)) begin
        bit_cnt <= bit_cnt + BC_W'(1);
        if (keep) rx_sr <= {rx_sr[DATA_W-2:0], SDout};
      end
      if (lr_fall) lhold <= rx_sr;
      if (lr_rise && state == RUN) begin
        lft_in <= lhold;
        rht_in <= rx_sr;
      end
    end
endmodule

// File: tb/tb_codec_serial_port.sv
// tb_codec_serial_port: directed checks of timing, loopback, I2S framing, enable hold, reset and warm-up
module tb_codec_serial_port;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;
  int checks = 0, errors = 0;

  logic rst0 = 1'b0, en0 = 1'b1;
  logic [15:0] lo0 = 16'hA5C3, ro0 = 16'h0F0F, li0, ri0;
  logic v0, lr0, sc0, mc0, rn0, sdi0;
  codec_serial_port u0 (.clk(clk), .rst(rst0), .enable(en0), .lft_out(lo0), .rht_out(ro0), .SDout(sdi0),
    .lft_in(li0), .rht_in(ri0), .valid(v0), .LRCLK(lr0), .SCLK(sc0), .MCLK(mc0), .RSTn(rn0), .SDin(sdi0));

  logic rst1 = 1'b0, en1 = 1'b1, sdo1 = 1'b0;
  logic [23:0] lo1 = 24'h800001, ro1 = 24'h7FFFFE, li1, ri1;
  logic v1, lr1, sc1, mc1, rn1, sdi1;
  codec_serial_port #(.DATA_W(24), .MODE(1), .SLOT_LOG2(5)) u1 (.clk(clk), .rst(rst1), .enable(en1),
    .lft_out(lo1), .rht_out(ro1), .SDout(sdo1), .lft_in(li1), .rht_in(ri1), .valid(v1), .LRCLK(lr1),
    .SCLK(sc1), .MCLK(mc1), .RSTn(rn1), .SDin(sdi1));

  logic rst2 = 1'b0, en2 = 1'b1;
  logic [15:0] lo2 = 16'h1111, ro2 = 16'h2222, li2, ri2;
  logic v2, lr2, sc2, mc2, rn2, sdi2;
  codec_serial_port #(.WARMUP_FRAMES(3)) u2 (.clk(clk), .rst(rst2), .enable(en2), .lft_out(lo2),
    .rht_out(ro2), .SDout(sdi2), .lft_in(li2), .rht_in(ri2), .valid(v2), .LRCLK(lr2), .SCLK(sc2),
    .MCLK(mc2), .RSTn(rn2), .SDin(sdi2));

  int nv0 = 0;
  always @(posedge clk) nv0 += int'(v0);

  // codec model for u1: I2S words MSB in 2nd SCLK, and a per-slot capture of SDin
  logic [23:0] cl = 24'h800001, cr = 24'h7FFFFE;
  logic [31:0] acc1 = '0, cap_l = '0, cap_r = '0;
  logic last_lr1 = 1'b1;
  int pos1 = 0;
  always @(sc1) begin
    #1;
    if (sc1) acc1 = {acc1[30:0], sdi1};
    else begin
      if (lr1 != last_lr1) begin
        if (lr1) cap_r = acc1;
        else cap_l = acc1;
        acc1 = '0;
        pos1 = 0;
        last_lr1 = lr1;
      end else pos1++;
      sdo1 = (pos1 >= 1 && pos1 <= 24) ? (lr1 ? cl[24-pos1] : cr[24-pos1]) : 1'b0;
    end
  end

  typedef struct packed { logic [15:0] l, r, el, er; } vec_t;
  vec_t tbl [4];

  function automatic logic sig(input int s);
    case (s)
      0: return lr0;
      1: return rn0;
      2: return sc0;
      3: return mc0;
      4: return v0;
      5: return v1;
      6: return v2;
      default: return rn2;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic wait_for(input int s, input logic lvl, input int budget, input string name, output int t);
    int n = 0;
    while (sig(s) !== lvl && n < budget) begin
      @(negedge clk);
      n++;
    end
    t = cyc;
    if (sig(s) !== lvl) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout after %0d clk waiting for %b", name, budget, lvl);
    end
  endtask

  task automatic rise(input int s, input int budget, input string name, output int t);
    wait_for(s, 1'b0, budget, name, t);
    wait_for(s, 1'b1, budget, name, t);
  endtask

  task automatic startup0(input string tag);
    int tf, tr, t0, t1, tl, tv, base;
    base = nv0;
    wait_for(0, 1'b0, 3000, {tag, " lrclk fall"}, tf);
    wait_for(1, 1'b1, 10, {tag, " rstn rise"}, tr);
    check({tag, " rstn after lrclk fall"}, tr - tf, 1);
    rise(2, 100, {tag, " sclk"}, t0);
    rise(2, 100, {tag, " sclk"}, t1);
    check({tag, " sclk period"}, t1 - t0, 32);
    rise(3, 10, {tag, " mclk"}, t0);
    rise(3, 10, {tag, " mclk"}, t1);
    check({tag, " mclk period"}, t1 - t0, 4);
    rise(0, 1100, {tag, " lrclk rise"}, tl);
    check({tag, " no valid before run"}, nv0 - base, 0);
    rise(4, 1100, {tag, " first valid"}, tv);
    check({tag, " first valid delay"}, tv - tl, 1024);
  endtask

  task automatic nxt(input int s, input int budget, input string name);
    int t;
    rise(s, budget, name, t);
  endtask

  initial begin
    int t, nsd, nvh, nlr, n;
    logic prev, found;
    logic [15:0] hl, hr;
    tbl = '{'{16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF},
            '{16'h8001, 16'h7FFE, 16'h8001, 16'h7FFE},
            '{16'hFFFF, 16'h0001, 16'hFFFF, 16'h0001},
            '{16'h1234, 16'hABCD, 16'h1234, 16'hABCD}};
    #1 rst0 = 1'b1;
    rst1 = 1'b1;
    rst2 = 1'b1;
    repeat (2) @(negedge clk);
    check("rst RSTn", rn0, 0);
    check("rst LRCLK", lr0, 1);
    check("rst SCLK", sc0, 0);
    check("rst MCLK", mc0, 0);
    check("rst valid", v0, 0);
    check("rst SDin", sdi0, 0);
    check("rst lft_in", li0, 0);
    check("rst rht_in", ri0, 0);
    rst0 = 1'b0;
    startup0("t1");
    nxt(4, 1100, "t2 valid2");
    nxt(4, 1100, "t2 valid3");
    check("t2 v3 lft_in", li0, 16'hA5C3);
    check("t2 v3 rht_in", ri0, 16'h0F0F);
    nxt(4, 1100, "t2 valid4");
    check("t2 v4 lft_in", li0, 16'hA5C3);
    check("t2 v4 rht_in", ri0, 16'h0F0F);
    for (int i = 0; i < 4; i++) begin
      lo0 = tbl[i].l;
      ro0 = tbl[i].r;
      repeat (3) nxt(4, 1100, "tbl valid");
      check($sformatf("tbl%0d lft_in", i), li0, tbl[i].el);
      check($sformatf("tbl%0d rht_in", i), ri0, tbl[i].er);
    end
    repeat (100) @(negedge clk);
    en0 = 1'b0;
    rise(4, 1100, "t4 frame-end valid", t);
    hl = li0;
    hr = ri0;
    nsd = 0;
    nvh = 0;
    nlr = 0;
    prev = lr0;
    for (int k = 0; k < 2100; k++) begin
      @(negedge clk);
      nsd += int'(sdi0);
      nvh += int'(v0);
      nlr += int'(lr0 != prev);
      prev = lr0;
    end
    check("t4 hold SDin ones", nsd, 0);
    check("t4 hold valids", nvh, 0);
    check("t4 hold lrclk toggles", nlr, 4);
    check("t4 hold lft_in", li0, hl);
    check("t4 hold rht_in", ri0, hr);
    en0 = 1'b1;
    nxt(4, 2200, "t4 resume valid");
    repeat (3) nxt(4, 1100, "t4 post valid");
    check("t4 resume lft_in", li0, 16'h1234);
    check("t4 resume rht_in", ri0, 16'hABCD);
    repeat (300) @(negedge clk);
    #2 rst0 = 1'b1;
    #1;
    check("t5 RSTn", rn0, 0);
    check("t5 LRCLK", lr0, 1);
    check("t5 lft_in", li0, 0);
    check("t5 rht_in", ri0, 0);
    check("t5 valid", v0, 0);
    @(negedge clk);
    rst0 = 1'b0;
    startup0("t5");
    repeat (2) nxt(4, 1100, "t5 valid");
    check("t5 data lft_in", li0, 16'h1234);
    check("t5 data rht_in", ri0, 16'hABCD);
    rst1 = 1'b0;
    repeat (4) nxt(5, 5000, "t3 valid");
    check("t3 lft_in", li1, 24'h800001);
    check("t3 rht_in", ri1, 24'h7FFFFE);
    check("t3 SDin left slot", cap_l, 32'h40000080);
    check("t3 SDin right slot", cap_r, 32'h3FFFFF00);
    rst2 = 1'b0;
    wait_for(7, 1'b1, 3000, "t6 rstn rise", t);
    n = 0;
    found = 1'b0;
    prev = lr2;
    for (int k = 0; k < 5000 && !found; k++) begin
      @(negedge clk);
      if (v2) found = 1'b1;
      else begin
        n += int'(!prev && lr2);
        prev = lr2;
      end
    end
    check("t6 valid seen", found, 1);
    check("t6 lrclk rises before valid", n, 3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
